// File: rtl/soft_tbm_pkg.sv
// Constants shared by the soft TBM header/trailer generator and the DAQ stream parser.
package soft_tbm_pkg;

  localparam logic [7:0] CODE_HDR1 = 8'hA0;
  localparam logic [7:0] CODE_HDR2 = 8'h80;
  localparam logic [7:0] CODE_TRL1 = 8'hE0;
  localparam logic [7:0] CODE_TRL2 = 8'hC0;

  localparam int ERR_FMT  = 0;
  localparam int ERR_EVN  = 1;
  localparam int ERR_TOK  = 2;
  localparam int ERR_OVF  = 3;
  localparam int ERR_ORPH = 4;
  localparam int ERR_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_BODY,
    ST_TRL2
  } state_t;

endpackage

// File: rtl/daq_event_slot.sv
// Single-entry valid/ready holding register; a load into a full, unreleased slot is dropped.
module daq_event_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] rec,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         lost
);

  logic accept;

  // The slot frees up on the same edge the consumer takes the old record.
  assign accept = !valid || ready;
  assign lost   = load && !accept;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && accept) begin
      valid <= 1'b1;
      data  <= rec;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/soft_tbm_daq_parser.sv
// Frames the soft TBM DAQ word stream into event records with error flags and statistics.
module soft_tbm_daq_parser #(
  parameter int CNT_W  = 12,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              din_write,
  input  logic [15:0]       din,
  input  logic              check_evn,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [7:0]        ev_number,
  output logic [3:0]        ev_trg_pos,
  output logic [7:0]        ev_trl1,
  output logic [7:0]        ev_trl2,
  output logic [CNT_W-1:0]  ev_payload,
  output logic [4:0]        ev_err,
  output logic [STAT_W-1:0] cnt_events,
  output logic [STAT_W-1:0] cnt_errors,
  output logic [STAT_W-1:0] cnt_lost
);
  import soft_tbm_pkg::*;

  localparam int REC_W = 8 + 4 + 8 + 8 + CNT_W + ERR_W;

  state_t           state_q, state_d;
  logic [7:0]       number_q, number_d;
  logic [3:0]       trg_pos_q, trg_pos_d;
  logic [7:0]       trl1_q, trl1_d;
  logic [CNT_W-1:0] payload_q, payload_d;
  logic             fmt_q, fmt_d, ovf_q, ovf_d, orphan_q, orphan_d;
  logic [7:0]       last_evn_q, last_evn_d, next_evn;
  logic             evn_known_q, evn_known_d;

  logic             word, close, start, close_fmt, lost;
  logic [7:0]       code, close_trl2;
  logic [ERR_W-1:0] close_err;
  logic [REC_W-1:0] rec, slot_data;

  assign word     = sync && din_write;
  assign code     = din[15:8];
  assign next_evn = last_evn_q + 8'd1;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    number_d    = number_q;
    trg_pos_d   = trg_pos_q;
    trl1_d      = trl1_q;
    payload_d   = payload_q;
    fmt_d       = fmt_q;
    ovf_d       = ovf_q;
    orphan_d    = orphan_q;
    last_evn_d  = last_evn_q;
    evn_known_d = evn_known_q;
    close       = 1'b0;
    start       = 1'b0;
    close_trl2  = 8'h00;
    close_fmt   = fmt_q;

    if (word) begin
      if (state_q == ST_HDR2) begin
        if (code == CODE_HDR2) begin
          trg_pos_d = din[3:0];
          state_d   = ST_BODY;
        end else begin
          fmt_d     = 1'b1;
          close_fmt = 1'b1;
          trg_pos_d = 4'h0;
        end
      end

      if (state_q == ST_TRL2) begin
        close = 1'b1;
        if (code == CODE_TRL2) begin
          close_trl2 = din[7:0];
          state_d    = ST_IDLE;
        end else begin
          close_fmt = 1'b1;
        end
      end

      // A bad second header is reinterpreted as body data in the same cycle.
      if (state_q == ST_BODY || (state_q == ST_HDR2 && code != CODE_HDR2)) begin
        if (code == CODE_TRL1) begin
          trl1_d  = din[7:0];
          state_d = ST_TRL2;
        end else if (code == CODE_HDR1) begin
          close     = 1'b1;
          close_fmt = 1'b1;
          start     = 1'b1;
        end else if (payload_q != '1) begin
          payload_d = payload_q + 1'b1;
          if (payload_d == '1) ovf_d = 1'b1;
        end
      end

      // A bad second trailer is reinterpreted as an idle-state word in the same cycle.
      if (state_q == ST_IDLE || (state_q == ST_TRL2 && code != CODE_TRL2)) begin
        if (code == CODE_HDR1) begin
          start = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          orphan_d = 1'b1;
        end
      end
    end

    close_err           = '0;
    close_err[ERR_FMT]  = close_fmt;
    close_err[ERR_EVN]  = check_evn && evn_known_q &&
                          (number_q != (trl1_q[3] ? 8'h00 : next_evn));
    close_err[ERR_TOK]  = trl1_q[7] && (payload_q != '0);
    close_err[ERR_OVF]  = ovf_q;
    close_err[ERR_ORPH] = orphan_q;

    if (close) begin
      last_evn_d  = number_q;
      evn_known_d = 1'b1;
      // An orphan seen while this event closes belongs to the following event.
      if (!(word && state_q == ST_TRL2 && code != CODE_TRL2 && code != CODE_HDR1))
        orphan_d = 1'b0;
    end

    if (start) begin
      number_d  = din[7:0];
      trg_pos_d = 4'h0;
      trl1_d    = 8'h00;
      payload_d = '0;
      fmt_d     = 1'b0;
      ovf_d     = 1'b0;
      state_d   = ST_HDR2;
    end
  end

  assign rec = {number_q, trg_pos_q, trl1_q, close_trl2, payload_q, close_err};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      number_q    <= '0;
      trg_pos_q   <= '0;
      trl1_q      <= '0;
      payload_q   <= '0;
      fmt_q       <= 1'b0;
      ovf_q       <= 1'b0;
      orphan_q    <= 1'b0;
      last_evn_q  <= '0;
      evn_known_q <= 1'b0;
      cnt_events  <= '0;
      cnt_errors  <= '0;
      cnt_lost    <= '0;
    end else begin
      state_q     <= state_d;
      number_q    <= number_d;
      trg_pos_q   <= trg_pos_d;
      trl1_q      <= trl1_d;
      payload_q   <= payload_d;
      fmt_q       <= fmt_d;
      ovf_q       <= ovf_d;
      orphan_q    <= orphan_d;
      last_evn_q  <= last_evn_d;
      evn_known_q <= evn_known_d;
      if (close && cnt_events != '1) cnt_events <= cnt_events + 1'b1;
      if (close && close_err != '0 && cnt_errors != '1) cnt_errors <= cnt_errors + 1'b1;
      if (lost && cnt_lost != '1) cnt_lost <= cnt_lost + 1'b1;
    end
  end

  daq_event_slot #(.W(REC_W)) u_slot (
    .clk   (clk),
    .reset (reset),
    .load  (close),
    .rec   (rec),
    .ready (ev_ready),
    .valid (ev_valid),
    .data  (slot_data),
    .lost  (lost)
  );

  assign {ev_number, ev_trg_pos, ev_trl1, ev_trl2, ev_payload, ev_err} = slot_data;

endmodule

// File: tb/tb_soft_tbm_daq_parser.sv
// Directed bench for soft_tbm_daq_parser: framing, error flags, handshake and counters.
module tb_soft_tbm_daq_parser;

  localparam int CNT_W  = 12;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset, sync, din_write, check_evn, ev_ready;
  logic [15:0]       din;
  logic              ev_valid;
  logic [7:0]        ev_number, ev_trl1, ev_trl2;
  logic [3:0]        ev_trg_pos;
  logic [CNT_W-1:0]  ev_payload;
  logic [4:0]        ev_err;
  logic [STAT_W-1:0] cnt_events, cnt_errors, cnt_lost;
  logic [44:0]       rec;

  int tests_run    = 0;
  int tests_failed = 0;

  soft_tbm_daq_parser #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .din_write  (din_write),
    .din        (din),
    .check_evn  (check_evn),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_number  (ev_number),
    .ev_trg_pos (ev_trg_pos),
    .ev_trl1    (ev_trl1),
    .ev_trl2    (ev_trl2),
    .ev_payload (ev_payload),
    .ev_err     (ev_err),
    .cnt_events (cnt_events),
    .cnt_errors (cnt_errors),
    .cnt_lost   (cnt_lost)
  );

  always #5 clk = ~clk;

  assign rec = {ev_number, ev_trg_pos, ev_trl1, ev_trl2, ev_payload, ev_err};

  task automatic do_reset();
    reset = 1'b1; sync = 1'b1; din_write = 1'b0; din = 16'h0000; ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic put(input logic [15:0] w);
    din = w; din_write = 1'b1; sync = 1'b1;
    @(posedge clk);
    #1 din_write = 1'b0;
  endtask

  task automatic send_event(input logic [7:0] num, input logic [7:0] trl1);
    put({8'hA0, num});
    put(16'h8000);
    put({8'hE0, trl1});
    put(16'hC000);
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(posedge clk);
    #1 ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    check_evn = 1'b0;
    do_reset();
    tests_run++;
    if (ev_valid !== 1'b0 || rec !== 45'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b rec=%h, want valid=0 rec=0", ev_valid, rec);
    end
    tests_run++;
    if ({cnt_events, cnt_errors, cnt_lost} !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got %h, want 0", {cnt_events, cnt_errors, cnt_lost});
    end
  endtask

  task automatic test_clean();
    do_reset();
    put(16'hA005); put(16'h8003); put(16'h1234); put(16'h5678);
    din = 16'h2222; din_write = 1'b1; sync = 1'b0;
    @(posedge clk);
    #1 din_write = 1'b0; sync = 1'b1;
    put(16'h9ABC); put(16'hE000);
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_early_valid: got %b, want 0", ev_valid);
    end
    put(16'hC002);
    tests_run++;
    if (ev_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL clean_valid: got %b, want 1", ev_valid);
    end
    tests_run++;
    if (rec !== {8'h05, 4'h3, 8'h00, 8'h02, 12'd3, 5'h00}) begin
      tests_failed++;
      $display("FAIL clean_record: got %h, want %h", rec, {8'h05, 4'h3, 8'h00, 8'h02, 12'd3, 5'h00});
    end
    tests_run++;
    if (cnt_events !== 16'd1 || cnt_errors !== 16'd0) begin
      tests_failed++;
      $display("FAIL clean_counters: got events=%0d errors=%0d, want 1 0", cnt_events, cnt_errors);
    end
    pop();
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_pop: got valid=%b, want 0", ev_valid);
    end
  endtask

  task automatic test_token();
    do_reset();
    send_event(8'h06, 8'h80);
    tests_run++;
    if (rec !== {8'h06, 4'h0, 8'h80, 8'h00, 12'd0, 5'h00}) begin
      tests_failed++;
      $display("FAIL token_empty: got %h, want %h", rec, {8'h06, 4'h0, 8'h80, 8'h00, 12'd0, 5'h00});
    end
    pop();
    put(16'hA006); put(16'h8000); put(16'h1111); put(16'hE080); put(16'hC000);
    tests_run++;
    if (rec !== {8'h06, 4'h0, 8'h80, 8'h00, 12'd1, 5'h04}) begin
      tests_failed++;
      $display("FAIL token_missing: got %h, want %h", rec, {8'h06, 4'h0, 8'h80, 8'h00, 12'd1, 5'h04});
    end
    tests_run++;
    if (cnt_events !== 16'd2 || cnt_errors !== 16'd1) begin
      tests_failed++;
      $display("FAIL token_counters: got events=%0d errors=%0d, want 2 1", cnt_events, cnt_errors);
    end
    pop();
  endtask

  task automatic test_evn();
    logic [7:0] nums [4] = '{8'hFF, 8'h00, 8'h02, 8'h07};
    logic [7:0] trls [4] = '{8'h00, 8'h00, 8'h00, 8'h08};
    logic [4:0] errs [4] = '{5'h00, 5'h00, 5'h02, 5'h02};
    do_reset();
    check_evn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_event(nums[i], trls[i]);
      tests_run++;
      if (rec !== {nums[i], 4'h0, trls[i], 8'h00, 12'd0, errs[i]}) begin
        tests_failed++;
        $display("FAIL evn_%0d: got %h, want %h", i, rec, {nums[i], 4'h0, trls[i], 8'h00, 12'd0, errs[i]});
      end
      pop();
    end
    check_evn = 1'b0;
  endtask

  task automatic test_framing();
    do_reset();
    put(16'hA001); put(16'h8000); put(16'hA002);
    tests_run++;
    if (ev_valid !== 1'b1 || rec !== {8'h01, 4'h0, 8'h00, 8'h00, 12'd0, 5'h01}) begin
      tests_failed++;
      $display("FAIL frame_midbody: got valid=%b %h, want 1 %h", ev_valid, rec, {8'h01, 4'h0, 8'h00, 8'h00, 12'd0, 5'h01});
    end
    pop();
    put(16'h8005); put(16'hE000); put(16'hC000);
    tests_run++;
    if (rec !== {8'h02, 4'h5, 8'h00, 8'h00, 12'd0, 5'h00}) begin
      tests_failed++;
      $display("FAIL frame_second: got %h, want %h", rec, {8'h02, 4'h5, 8'h00, 8'h00, 12'd0, 5'h00});
    end
    pop();
    put(16'hE000);
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_orphan_valid: got %b, want 0", ev_valid);
    end
    send_event(8'h03, 8'h00);
    tests_run++;
    if (rec !== {8'h03, 4'h0, 8'h00, 8'h00, 12'd0, 5'h10}) begin
      tests_failed++;
      $display("FAIL frame_orphan: got %h, want %h", rec, {8'h03, 4'h0, 8'h00, 8'h00, 12'd0, 5'h10});
    end
    pop();
    put(16'hA008); put(16'h8000); put(16'hE000); put(16'hA009);
    tests_run++;
    if (rec !== {8'h08, 4'h0, 8'h00, 8'h00, 12'd0, 5'h01}) begin
      tests_failed++;
      $display("FAIL frame_bad_trl2: got %h, want %h", rec, {8'h08, 4'h0, 8'h00, 8'h00, 12'd0, 5'h01});
    end
    pop();
    put(16'h8000); put(16'hE000); put(16'hC000);
    tests_run++;
    if (rec !== {8'h09, 4'h0, 8'h00, 8'h00, 12'd0, 5'h00} || cnt_events !== 16'd5 || cnt_errors !== 16'd3) begin
      tests_failed++;
      $display("FAIL frame_recovery: got %h ev=%0d er=%0d, want %h ev=5 er=3", rec, cnt_events, cnt_errors,
               {8'h09, 4'h0, 8'h00, 8'h00, 12'd0, 5'h00});
    end
    pop();
  endtask

  task automatic test_backpressure();
    do_reset();
    put(16'hA011); put(16'h8000); put(16'h4444); put(16'hE000); put(16'hC001);
    send_event(8'h12, 8'h00);
    tests_run++;
    if (ev_valid !== 1'b1 || rec !== {8'h11, 4'h0, 8'h00, 8'h01, 12'd1, 5'h00}) begin
      tests_failed++;
      $display("FAIL bp_held: got valid=%b %h, want 1 %h", ev_valid, rec, {8'h11, 4'h0, 8'h00, 8'h01, 12'd1, 5'h00});
    end
    tests_run++;
    if (cnt_lost !== 16'd1 || cnt_events !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_counters: got lost=%0d events=%0d, want 1 2", cnt_lost, cnt_events);
    end
    pop();
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b, want 0", ev_valid);
    end
  endtask

  task automatic test_reset_mid_event();
    do_reset();
    check_evn = 1'b1;
    put(16'hA003); put(16'h8001);
    do_reset();
    put(16'hA004); put(16'h8001); put(16'hE000); put(16'hC000);
    tests_run++;
    if (rec !== {8'h04, 4'h1, 8'h00, 8'h00, 12'd0, 5'h00}) begin
      tests_failed++;
      $display("FAIL rstmid_record: got %h, want %h", rec, {8'h04, 4'h1, 8'h00, 8'h00, 12'd0, 5'h00});
    end
    tests_run++;
    if (cnt_events !== 16'd1 || cnt_errors !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstmid_counters: got events=%0d errors=%0d, want 1 0", cnt_events, cnt_errors);
    end
    pop();
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_single: got valid=%b, want 0", ev_valid);
    end
    check_evn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_token();
    test_evn();
    test_framing();
    test_backpressure();
    test_reset_mid_event();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
